// File: rtl/mem_responder.sv
// LC-3 MAR/MDR memory responder: services one read or write per MEM_EN request after a
// fixed number of wait states, with 16'hFFFF decoded as switch/hex-display I/O.
module mem_responder #(
    parameter int WAIT_STATES = 2,
    parameter int DEPTH_LOG2  = 8
) (
    input  logic        Clk,
    input  logic        Reset_al,
    input  logic        MEM_EN,
    input  logic        MEM_WE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic [15:0] Switches,
    output logic [15:0] MDR_In,
    output logic        MEM_R,
    output logic [15:0] HEX_Out,
    output logic        Busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_HOLD
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [15:0]     addr_q, addr_d;
    logic [15:0]     data_q, data_d;
    logic            we_q, we_d;
    logic [15:0]     hex_q, hex_d;
    logic            mem_r_q, mem_r_d;
    logic [15:0]     mdr_in_q;
    logic [15:0]     mem_array [DEPTH];

    logic [15:0]           req_addr;
    logic [15:0]           req_data;
    logic                  req_we;
    logic                  enter_done;
    logic                  is_io;
    logic                  arr_wr;
    logic                  rd_fire;
    logic [DEPTH_LOG2-1:0] idx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = we_q;

        // With zero wait states the access completes on the accepting edge, so the
        // live inputs stand in for the not-yet-latched request.
        if (state_q == ST_IDLE) begin
            req_addr = MAR;
            req_data = MDR;
            req_we   = MEM_WE;
        end else begin
            req_addr = addr_q;
            req_data = data_q;
            req_we   = we_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (MEM_EN) begin
                    addr_d  = MAR;
                    data_d  = MDR;
                    we_d    = MEM_WE;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!MEM_EN) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = ST_DONE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_HOLD;
            ST_HOLD: begin
                if (!MEM_EN) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        enter_done = (state_d == ST_DONE);
        is_io      = (req_addr == 16'hFFFF);
        idx        = req_addr[DEPTH_LOG2-1:0];
        arr_wr     = enter_done && req_we && !is_io;
        rd_fire    = enter_done && !req_we;
        mem_r_d    = enter_done;
        hex_d      = (enter_done && req_we && is_io) ? req_data : hex_q;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_al) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 16'd0;
            data_q  <= 16'd0;
            we_q    <= 1'b0;
            hex_q   <= 16'd0;
            mem_r_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            hex_q   <= hex_d;
            mem_r_q <= mem_r_d;
        end
    end

    // Array kept reset-free so it maps onto block RAM; reset only gates the write.
    always_ff @(posedge Clk) begin
        if (Reset_al && arr_wr) mem_array[idx] <= req_data;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_al) begin
            mdr_in_q <= 16'd0;
        end else if (rd_fire) begin
            mdr_in_q <= is_io ? Switches : mem_array[idx];
        end
    end

    assign MDR_In  = mdr_in_q;
    assign MEM_R   = mem_r_q;
    assign HEX_Out = hex_q;
    assign Busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (WAIT_STATES=2, DEPTH_LOG2=8); inputs change and
// outputs are sampled on the falling edge.
module tb_mem_responder;

  logic        clk;
  logic        reset_al;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic [15:0] switches;
  logic [15:0] mdr_in;
  logic        mem_r;
  logic [15:0] hex_out;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  mem_responder #(.WAIT_STATES(2), .DEPTH_LOG2(8)) dut (
    .Clk      (clk),
    .Reset_al (reset_al),
    .MEM_EN   (mem_en),
    .MEM_WE   (mem_we),
    .MAR      (mar),
    .MDR      (mdr),
    .Switches (switches),
    .MDR_In   (mdr_in),
    .MEM_R    (mem_r),
    .HEX_Out  (hex_out),
    .Busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Raise a request and wait (bounded) for MEM_R; lat is cycles after the accepting edge,
  // 0 if MEM_R never came.
  task automatic do_access(input logic we, input logic [15:0] addr, input logic [15:0] data,
                           input logic swap_mar, input logic [15:0] mar2,
                           output int lat, output logic [15:0] rdata);
    mem_en = 1'b1;
    mem_we = we;
    mar    = addr;
    mdr    = data;
    lat    = 0;
    rdata  = 16'hxxxx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (swap_mar && c == 1) mar = mar2;
      if (mem_r) begin
        lat   = c;
        rdata = mdr_in;
        break;
      end
    end
  endtask

  task automatic finish_access(input string tag);
    @(negedge clk);
    check_eq({tag, "_pulse_end"}, {15'd0, mem_r}, 16'd0);
    mem_en = 1'b0;
    @(negedge clk);
    check_eq({tag, "_idle_busy"}, {15'd0, busy}, 16'd0);
  endtask

  task automatic write_word(input string tag, input logic [15:0] addr, input logic [15:0] data);
    int lat;
    logic [15:0] rd;
    do_access(1'b1, addr, data, 1'b0, 16'd0, lat, rd);
    check_eq({tag, "_lat"}, 16'(lat), 16'd3);
    finish_access(tag);
  endtask

  task automatic read_word(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    int lat;
    logic [15:0] rd;
    do_access(1'b0, addr, 16'd0, 1'b0, 16'd0, lat, rd);
    check_eq({tag, "_lat"}, 16'(lat), 16'd3);
    check_eq({tag, "_data"}, rd, exp);
    finish_access(tag);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [15:0] rd;

    reset_al = 1'b0;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mar      = 16'd0;
    mdr      = 16'd0;
    switches = 16'h0000;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_mdr_in", mdr_in, 16'd0);
    check_eq("rst_hex", hex_out, 16'd0);
    check_eq("rst_mem_r", {15'd0, mem_r}, 16'd0);
    check_eq("rst_busy", {15'd0, busy}, 16'd0);
    reset_al = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_r) pulses++;
    end
    check_eq("idle_no_mem_r", 16'(pulses), 16'd0);

    // Write then read back
    write_word("wr_beef", 16'h0012, 16'hBEEF);
    read_word("rd_beef", 16'h0012, 16'hBEEF);

    // Aliasing and I/O write
    write_word("wr_alias", 16'h0105, 16'h1234);
    read_word("rd_alias", 16'h0005, 16'h1234);
    write_word("wr_00ff", 16'h00FF, 16'h7777);
    write_word("wr_hex", 16'hFFFF, 16'h5555);
    check_eq("hex_out", hex_out, 16'h5555);
    check_eq("mdr_in_held", mdr_in, 16'h1234);
    read_word("rd_00ff", 16'h00FF, 16'h7777);

    // I/O read
    switches = 16'h00A7;
    read_word("rd_sw", 16'hFFFF, 16'h00A7);
    switches = 16'h0000;

    // Held MEM_EN: one pulse only
    do_access(1'b1, 16'h0030, 16'h0101, 1'b0, 16'd0, lat, rd);
    check_eq("held_lat", 16'(lat), 16'd3);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_r) pulses++;
    end
    check_eq("held_extra_pulses", 16'(pulses), 16'd0);
    check_eq("held_busy", {15'd0, busy}, 16'd1);
    mem_en = 1'b0;
    @(negedge clk);
    read_word("rd_held", 16'h0030, 16'h0101);

    // MAR change during WAIT is ignored
    write_word("wr_0040", 16'h0040, 16'h4040);
    write_word("wr_0041", 16'h0041, 16'h1111);
    do_access(1'b0, 16'h0040, 16'd0, 1'b1, 16'h0041, lat, rd);
    check_eq("latch_lat", 16'(lat), 16'd3);
    check_eq("latch_data", rd, 16'h4040);
    finish_access("latch");

    // Abort during WAIT
    write_word("wr_old", 16'h0020, 16'h0F0F);
    mem_en = 1'b1;
    mem_we = 1'b1;
    mar    = 16'h0020;
    mdr    = 16'hAAAA;
    @(negedge clk);
    check_eq("abort_busy_wait", {15'd0, busy}, 16'd1);
    mem_en = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mem_r) pulses++;
    end
    check_eq("abort_no_mem_r", 16'(pulses), 16'd0);
    check_eq("abort_busy", {15'd0, busy}, 16'd0);
    read_word("rd_after_abort", 16'h0020, 16'h0F0F);

    // Reset during WAIT
    mem_en = 1'b1;
    mem_we = 1'b1;
    mar    = 16'h0020;
    mdr    = 16'hAAAA;
    @(negedge clk);
    reset_al = 1'b0;
    mem_en   = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_mdr_in", mdr_in, 16'd0);
    check_eq("mid_rst_hex", hex_out, 16'd0);
    check_eq("mid_rst_mem_r", {15'd0, mem_r}, 16'd0);
    check_eq("mid_rst_busy", {15'd0, busy}, 16'd0);
    reset_al = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mem_r) pulses++;
    end
    check_eq("mid_rst_no_mem_r", 16'(pulses), 16'd0);
    read_word("rd_after_rst", 16'h0020, 16'h0F0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the LC-3 datapath's MAR/MDR memory port. It accepts read and write requests from the CPU control FSM and services them after a programmable number of wait states. Read data is returned on `MDR_In` with a one-cycle ready pulse, and writes are committed to an on-chip word array. Address `16'hFFFF` is memory-mapped I/O: reads return the switches and writes load the hex-display register.

## Interface
- `WAIT_STATES`, default 2: idle cycles inserted between request acceptance and completion; legal range 0–15.
- `DEPTH_LOG2`, default 8: log2 of the word-array depth (default 256 × 16).
- `Clk` input 1: sole clock; all state updates on its rising edge.
- `Reset_al` input 1: reset, synchronous and active-low.
- `MEM_EN` input 1: request valid; level, held by the CPU until `MEM_R` is seen.
- `MEM_WE` input 1: 1 = write, 0 = read; sampled with `MEM_EN`.
- `MAR` input 16: request address.
- `MDR` input 16: write data.
- `Switches` input 16: I/O read source for address `16'hFFFF`.
- `MDR_In` output 16: read data returned to the MDR input mux.
- `MEM_R` output 1: ready; one-cycle pulse on completion of a read or a write.
- `HEX_Out` output 16: I/O write register, driving the hex displays.
- `Busy` output 1: high in every state except IDLE.

## Operation
- States:
  - IDLE: no request in service.
  - WAIT: counting down the wait states.
  - DONE: completion cycle, `MEM_R` = 1.
  - HOLD: waiting for the CPU to drop `MEM_EN`.
- IDLE:
  - On `MEM_EN` = 1, latch `MAR`, `MDR` and `MEM_WE` into request registers.
  - Load the wait counter with `WAIT_STATES`.
  - Go to WAIT, or go straight to DONE if `WAIT_STATES` = 0.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to DONE on the next edge.
  - If `MEM_EN` drops while in WAIT, abort: return to IDLE, perform no write, assert no `MEM_R`.
- Transition into DONE (same edge that makes `MEM_R` = 1):
  - Read, array address: `MDR_In` ← array[addr[DEPTH_LOG2-1:0]].
  - Read, address `16'hFFFF`: `MDR_In` ← `Switches`, sampled on that edge.
  - Write, array address: array[addr[DEPTH_LOG2-1:0]] ← latched data.
  - Write, address `16'hFFFF`: `HEX_Out` ← latched data; the array is not written.
- DONE lasts exactly one cycle, then goes to HOLD.
- HOLD: stay until `MEM_EN` = 0, then go to IDLE. A held-high `MEM_EN` never starts a second access.
- Address aliasing: only the low `DEPTH_LOG2` bits index the array, so addresses wrap modulo 2^DEPTH_LOG2. The exception is `16'hFFFF`, which always decodes to I/O (it is not aliased into the array).
- Latched request: changes on `MAR`, `MDR` or `MEM_WE` after acceptance are ignored.
- `MDR_In` holds its last read value across writes, idles and aborts. It is updated only by a completed read.

## Timing
- Reset (`Reset_al` = 0 at a rising edge):
  - State ← IDLE, counter ← 0, `MEM_R` ← 0, `Busy` ← 0, `MDR_In` ← 0, `HEX_Out` ← 0.
  - Array contents are not cleared.
  - Reset mid-access takes priority over all else; any write not yet committed is discarded.
- Latency: request seen at edge 0 → `MEM_R` high during cycle `WAIT_STATES`+1. With `WAIT_STATES` = 0 this is cycle 1.
- `MDR_In` is valid in the same cycle `MEM_R` is high and stays stable afterwards.
- Minimum request spacing: `MEM_EN` must be low for at least 1 cycle (the HOLD → IDLE edge). A new request is accepted on the edge after IDLE is re-entered.
- `MEM_R` is registered and never asserts outside DONE.
- `Busy` is a combinational decode of state ≠ IDLE.
- Array reads are synchronous (registered into `MDR_In`), so the array maps to block RAM.

## Test plan
- Reset: drive `Reset_al` = 0 for 2 cycles → `MDR_In` = 0, `HEX_Out` = 0, `MEM_R` = 0, `Busy` = 0. Release reset; idle for 10 cycles → no `MEM_R`.
- Write/read with `WAIT_STATES` = 2:
  - Write `16'hBEEF` to `16'h0012` → `MEM_R` pulses exactly 3 cycles after acceptance, for 1 cycle.
  - Drop `MEM_EN`, then read `16'h0012` → `MDR_In` = `16'hBEEF` in the `MEM_R` cycle.
- Aliasing with `DEPTH_LOG2` = 8:
  - Write `16'h1234` to `16'h0105`; read `16'h0005` → `16'h1234`.
  - Write `16'h5555` to `16'hFFFF` → `HEX_Out` = `16'h5555`; array[`8'hFF`] unchanged.
- I/O read: `Switches` = `16'h00A7`, read `16'hFFFF` → `MDR_In` = `16'h00A7`.
- Held `MEM_EN` and operand changes:
  - Hold `MEM_EN` high for 10 cycles after `MEM_R` → exactly one `MEM_R` pulse.
  - Change `MAR` during WAIT → the originally latched address is serviced.
- Abort and reset mid-access:
  - Start a write of `16'hAAAA` to `16'h0020`, drop `MEM_EN` during WAIT → no `MEM_R`; a subsequent read of `16'h0020` returns the old value.
  - Repeat, but assert `Reset_al` = 0 during WAIT instead → same result, and all outputs at their reset values.
